// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: one countdown per architectural register holding
// the cycles left until its pending result can be forwarded; stalls decode on a live source.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 3,
    parameter int LAT_W      = 2,
    parameter int ZERO_REG   = 0,
    parameter int PERF_W     = 16,
    localparam int NUM_REGS  = 2 ** REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_wr_en,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [LAT_W-1:0]      id_lat,
    output logic                  stallD,
    output logic [NUM_REGS-1:0]   pending,
    output logic [PERF_W-1:0]     stall_count
);

    logic [LAT_W-1:0]    cnt_q [NUM_REGS];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS];
    logic [PERF_W-1:0]   stall_cnt_q;
    logic [PERF_W-1:0]   stall_cnt_d;
    logic [NUM_REGS-1:0] pend;
    logic                rs1_hit;
    logic                rs2_hit;
    logic                rd_writable;
    logic                stall;
    logic                issue;

    // A hardwired register 0 is masked here, so index 0 can neither stall nor read pending.
    always_comb begin
        pend = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend[r] = (cnt_q[r] != '0);
        end
        if (ZERO_REG != 0) begin
            pend[0] = 1'b0;
        end
    end

    always_comb begin
        rs1_hit     = id_use_rs1 & pend[id_rs1];
        rs2_hit     = id_use_rs2 & pend[id_rs2];
        stall       = id_valid & (rs1_hit | rs2_hit);
        rd_writable = (ZERO_REG == 0) || (id_rd != '0);
        issue       = id_valid & ~stall & id_wr_en & rd_writable;
    end

    // Issue re-arms the destination ahead of the decrement, so a WAW takes the younger latency.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && (id_rd == REG_ADDR_W'(r))) begin
                cnt_d[r] = id_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallD      = stall;
    assign pending     = pend;
    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (default, and ZERO_REG=1 with PERF_W=4) checked
// every cycle against a model that tracks the cycle at which each register becomes ready.
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       v, u1, u2, we;
    logic [2:0] rs1, rs2, rd;
    logic [1:0] lat;

    logic        stall_a, stall_b;
    logic [7:0]  pend_a, pend_b;
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int n_checks;
    int n_pass;

    // Model: ready[i][r] is the first cycle at which register r no longer stalls a consumer.
    longint cyc;
    longint ready [2][8];
    int     sc    [2];
    int     zr    [2] = '{0, 1};
    int     sc_max[2] = '{65535, 15};

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst), .id_valid(v), .id_use_rs1(u1), .id_use_rs2(u2),
        .id_rs1(rs1), .id_rs2(rs2), .id_wr_en(we), .id_rd(rd), .id_lat(lat),
        .stallD(stall_a), .pending(pend_a), .stall_count(sc_a)
    );

    hazard_scoreboard #(.ZERO_REG(1), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(v), .id_use_rs1(u1), .id_use_rs2(u2),
        .id_rs1(rs1), .id_rs2(rs2), .id_wr_en(we), .id_rd(rd), .id_lat(lat),
        .stallD(stall_b), .pending(pend_b), .stall_count(sc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit m_pend(int i, int r);
        if (zr[i] != 0 && r == 0) return 1'b0;
        return cyc < ready[i][r];
    endfunction

    function automatic bit m_stall(int i);
        return v && ((u1 && m_pend(i, int'(rs1))) || (u2 && m_pend(i, int'(rs2))));
    endfunction

    function automatic logic [7:0] m_pvec(int i);
        logic [7:0] p;
        for (int r = 0; r < 8; r++) p[r] = m_pend(i, r);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sc[i] = 0;
            for (int r = 0; r < 8; r++) ready[i][r] = 0;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Drive one decode slot, compare at the falling edge, then advance the model across the rising edge.
    task automatic step(input logic i_v, input logic i_u1, input logic i_u2, input logic [2:0] i_rs1,
                        input logic [2:0] i_rs2, input logic i_we, input logic [2:0] i_rd,
                        input logic [1:0] i_lat);
        bit s [2];
        v = i_v; u1 = i_u1; u2 = i_u2; rs1 = i_rs1; rs2 = i_rs2;
        we = i_we; rd = i_rd; lat = i_lat;
        @(negedge clk);
        for (int i = 0; i < 2; i++) s[i] = m_stall(i);
        check("stall_a", 32'(stall_a), 32'(s[0]));
        check("stall_b", 32'(stall_b), 32'(s[1]));
        check("pend_a", 32'(pend_a), 32'(m_pvec(0)));
        check("pend_b", 32'(pend_b), 32'(m_pvec(1)));
        check("count_a", 32'(sc_a), 32'(sc[0]));
        check("count_b", 32'(sc_b), 32'(sc[1]));
        for (int i = 0; i < 2; i++) begin
            if (s[i]) begin
                if (sc[i] < sc_max[i]) sc[i]++;
            end else if (v && we && !(zr[i] != 0 && rd == 3'd0)) begin
                ready[i][rd] = cyc + 1 + longint'(lat);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 2'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        model_reset();
        rst = 1'b1;
        v = 0; u1 = 0; u2 = 0; rs1 = 0; rs2 = 0; we = 0; rd = 0; lat = 0;
        #1;
        check("reset_pend", 32'(pend_a), 32'h0);
        check("reset_stall", 32'(stall_a), 32'h0);
        check("reset_count", 32'(sc_a), 32'h0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Load-use: one stall, consumer issues on its second cycle.
        step(1, 0, 0, 0, 0, 1, 3, 1);
        step(1, 1, 0, 3, 0, 1, 4, 0);
        step(1, 1, 0, 3, 0, 1, 4, 0);
        check("loaduse_cnt", 32'(sc_a), 32'd1);
        idle();

        // Long latency producer: three stalls on a used rs2.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 5, 3);
        for (int k = 0; k < 4; k++) step(1, 0, 1, 0, 5, 0, 0, 0);
        check("longlat_cnt", 32'(sc_a), 32'd3);
        check("longlat_pend", 32'(pend_a), 32'h0);

        // Same register as an unused source: no stalls.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 5, 3);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 5, 0, 0, 0);
        check("unused_cnt", 32'(sc_a), 32'd0);

        // WAW overwrite with a shorter latency.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 2, 3);
        step(1, 0, 0, 0, 0, 1, 2, 1);
        step(1, 1, 0, 2, 0, 0, 0, 0);
        step(1, 1, 0, 2, 0, 0, 0, 0);
        check("waw_cnt", 32'(sc_a), 32'd1);
        idle();
        idle();

        // Register 0 as destination: three stalls when tracked, none when hardwired.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 0, 3);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("zero_cnt_a", 32'(sc_a), 32'd3);
        check("zero_cnt_b", 32'(sc_b), 32'd0);

        // Asynchronous reset between edges while r3 and r5 are pending.
        pulse_reset();
        step(1, 0, 0, 0, 0, 1, 3, 3);
        step(1, 0, 0, 0, 0, 1, 5, 3);
        v = 1; u1 = 1; u2 = 0; rs1 = 3; we = 0;
        #1;
        check("pre_rst_pend", 32'(pend_a), 32'h28);
        check("pre_rst_stall", 32'(stall_a), 32'h1);
        rst = 1'b1;
        #1;
        check("async_pend", 32'(pend_a), 32'h0);
        check("async_stall", 32'(stall_a), 32'h0);
        check("async_count", 32'(sc_a), 32'h0);
        rst = 1'b0;
        model_reset();
        step(1, 1, 0, 3, 0, 0, 0, 0);

        // Self-dependent re-arm on r7: 3 stalls per issue, 18 over 24 cycles; 4-bit counter saturates.
        pulse_reset();
        for (int k = 0; k < 24; k++) step(1, 1, 0, 7, 0, 1, 7, 3);
        check("sat_cnt_a", 32'(sc_a), 32'd18);
        check("sat_cnt_b", 32'(sc_b), 32'd15);

        // Random traffic with occasional resets.
        pulse_reset();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) != 0),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
